// File: rtl/nf10_pkt_pacing_sched.sv
// Round-robin AXI4-Stream packet scheduler with programmable inter-packet idle gap.
// Optional macro SCHED_PKT_CNT_EN adds per-port forwarded-packet counters on pkt_cnt.
module nf10_pkt_pacing_sched #(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_GAP_WIDTH        = 32
) (
  input  logic                                              axi_aclk,
  input  logic                                              axi_areset,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]        s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                            s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                            s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                    m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                     m_axis_tuser,
  output logic                                              m_axis_tvalid,
  output logic                                              m_axis_tlast,
  input  logic                                              m_axis_tready,
  input  logic                                              sw_rst,
  input  logic                                              sched_en,
  input  logic [C_NUM_PORTS-1:0]                            port_en,
  input  logic [C_GAP_WIDTH-1:0]                            gap_cycles,
  output logic [$clog2(C_NUM_PORTS)-1:0]                    grant_idx,
  output logic                                              busy
`ifdef SCHED_PKT_CNT_EN
  ,
  output logic [C_NUM_PORTS*32-1:0]                         pkt_cnt
`endif
);

  // state | meaning
  // IDLE  | no grant; arbitrate among enabled, valid ports
  // XFER  | granted port streams through until tlast handshake
  // GAP   | idle pacing, gap_cycles cycles, then back to IDLE
  localparam int NP  = C_NUM_PORTS;
  localparam int DW  = C_AXIS_DATA_WIDTH;
  localparam int SW  = C_AXIS_DATA_WIDTH / 8;
  localparam int UW  = C_AXIS_TUSER_WIDTH;
  localparam int GIW = $clog2(C_NUM_PORTS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GIW-1:0]         grant_q, grant_d;
  logic [GIW-1:0]         last_q, last_d;
  logic [C_GAP_WIDTH-1:0] cnt_q, cnt_d;

  logic [NP-1:0]  req;
  logic           win_vld;
  logic [GIW-1:0] win_idx;
  logic           xfer;
  logic           pkt_end;

  assign req = s_axis_tvalid & port_en & {NP{sched_en}};

  // Scan starts one past the last served port so every port gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NP; k++) begin
      if (!win_vld && req[(int'(last_q) + k) % NP]) begin
        win_vld = 1'b1;
        win_idx = GIW'((int'(last_q) + k) % NP);
      end
    end
  end

  assign xfer          = (state_q == ST_XFER);
  assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*DW +: DW];
  assign m_axis_tstrb  = s_axis_tstrb[int'(grant_q)*SW +: SW];
  assign m_axis_tuser  = s_axis_tuser[int'(grant_q)*UW +: UW];
  assign m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
  assign m_axis_tlast  = xfer & s_axis_tlast[grant_q];
  assign s_axis_tready = xfer ? (NP'(m_axis_tready) << grant_q) : '0;
  assign pkt_end       = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign grant_idx     = grant_q;
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (pkt_end) begin
          last_d = grant_q;
          if (gap_cycles == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = gap_cycles;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= C_GAP_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Soft reset truncates any packet in flight; upstream must flush.
    if (sw_rst) begin
      state_d = ST_IDLE;
      grant_d = '0;
      last_d  = GIW'(NP - 1);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GIW'(NP - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SCHED_PKT_CNT_EN
  logic [31:0] pkt_cnt_q [NP];

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      for (int i = 0; i < NP; i++) pkt_cnt_q[i] <= '0;
    end else if (sw_rst) begin
      for (int i = 0; i < NP; i++) pkt_cnt_q[i] <= '0;
    end else if (pkt_end) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
  end
`endif

endmodule
